ram_loader: RTL
===============

// Module: ram_loader
// PURPOSE
//  Byte-stream program loader that sits directly upstream of the synchronous RAM.
//  Consumes framed bytes (e.g. from a UART receiver) and writes 16-bit words into RAM.
//  Holds the CPU off the bus while loading; otherwise passes CPU RAM signals through.
//  Frame format: 0xA5, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, {D_HI, D_LO} x LEN, CSUM.
// PARAMETERS
//  ADDR_WIDTH      16      RAM address bits (<=16); low ADDR_WIDTH bits of the ADDR field are used
//  TIMEOUT_CYCLES  1000000 idle clocks mid-frame before abort to ERR
// PORTS
//  clk       in   1           system clock, all logic on posedge
//  reset_    in   1           asynchronous, active-low reset
//  rx_data   in   8           received byte
//  rx_valid  in   1           1-cycle strobe, rx_data valid; may be back-to-back; no backpressure
//  cpu_addr  in   ADDR_WIDTH  CPU RAM address (pass-through when idle)
//  cpu_din   in   16          CPU write data (pass-through when idle)
//  cpu_we_   in   1           CPU write enable, active low (pass-through when idle)
//  ram_addr  out  ADDR_WIDTH  to RAM addr
//  ram_din   out  16          to RAM din
//  ram_we_   out  1           to RAM we_, active low
//  cpu_hold  out  1           high while frame in progress; CPU must stall
//  busy      out  1           high in any state other than IDLE
//  done      out  1           1-cycle pulse: frame completed, checksum good
//  error     out  1           sticky: checksum mismatch or timeout; cleared on next header
// BEHAVIOUR
//  Reset: state=IDLE, ld_we_=1, ld_addr=0, ld_din=0, csum=0, cpu_hold=0, busy=0, done=0, error=0.
//  States: IDLE->ADDR_HI->ADDR_LO->LEN_HI->LEN_LO->DATA_HI<->DATA_LO->CHECK->IDLE.
//  - IDLE: rx_valid & rx_data==8'hA5 -> ADDR_HI, clear error, clear csum; other bytes ignored.
//  - ADDR_HI/LO, LEN_HI/LO: each accepted byte latches the field and advances one state.
//  - LEN_LO: LEN==0 -> CHECK, else -> DATA_HI.
//  - DATA_HI: latch hi byte. DATA_LO: latch lo byte; next cycle ld_we_=0 for exactly one
//    cycle with ld_addr=current address, ld_din={hi,lo}; address then increments mod
//    2^ADDR_WIDTH (0xFFFF+1 wraps to 0); remaining count decrements; count==0 -> CHECK.
//  - csum = 8-bit sum (mod 256) of all data bytes only (header/addr/len excluded).
//  - CHECK: byte==csum -> done pulse 1 cycle later, IDLE; else error=1, IDLE.
//  - Timeout: any non-IDLE state with no rx_valid for TIMEOUT_CYCLES clocks -> error=1, IDLE;
//    words already written stay written. Timer reloads on every accepted byte.
//  - 0xA5 received mid-frame is data, not a resync.
//  - Write issue and a new rx_valid in the same cycle: both handled, no byte dropped.
//  Bus mux (combinational): busy=0 -> ram_* = cpu_*; busy=1 -> ram_addr=ld_addr,
//    ram_din=ld_din, ram_we_=ld_we_ (cpu_we_ ignored, no CPU writes during load).
//  cpu_hold = busy, except it also stays high the cycle the final write issues.
//  Latency: last data byte -> RAM write strobe 1 clk; CSUM byte -> done 1 clk.
//  reset_ low mid-frame: immediate return to reset values; partial frame discarded.
// STRUCTURE
//  Shared package/include: LDR_HEADER=8'hA5, state encoding localparams (4-bit).
//  One sub-module: loader_timer (loadable down-counter, TIMEOUT_CYCLES, expire pulse).
//  FSM, field registers, checksum, and bus mux stay in ram_loader.
// TESTING
//  1) A5 01 00 00 02 12 34 AB CD BE -> writes 0x1234@0x0100, 0xABCD@0x0101; done pulse; error=0.
//  2) Same frame, CSUM=00 -> both words written, no done, error=1; next A5 clears error.
//  3) A5 FF FF 00 02 00 01 00 02 03 -> writes @0xFFFF then @0x0000 (wrap); done.
//  4) A5 00 10 00 00 00 -> no write strobe, done pulse; then bytes 55 66 in IDLE ignored.
//  5) A5 00 20 00 03 11 22, then silence > TIMEOUT_CYCLES -> 0x1122@0x0020 written, error=1, busy=0.
//  6) Assert reset_ low after LEN_LO; verify all outputs at reset values, cpu_* pass-through restored.

Source files
------------

// File: rtl/ram_loader_pkg.sv
// Shared constants for the byte-stream RAM loader: frame header and FSM encoding.
package ram_loader_pkg;

   localparam logic [7:0] LDR_HEADER = 8'hA5;

   localparam logic [3:0] ST_IDLE    = 4'd0;
   localparam logic [3:0] ST_ADDR_HI = 4'd1;
   localparam logic [3:0] ST_ADDR_LO = 4'd2;
   localparam logic [3:0] ST_LEN_HI  = 4'd3;
   localparam logic [3:0] ST_LEN_LO  = 4'd4;
   localparam logic [3:0] ST_DATA_HI = 4'd5;
   localparam logic [3:0] ST_DATA_LO = 4'd6;
   localparam logic [3:0] ST_CHECK   = 4'd7;

   typedef enum logic [3:0] {
      S_IDLE    = ST_IDLE,
      S_ADDR_HI = ST_ADDR_HI,
      S_ADDR_LO = ST_ADDR_LO,
      S_LEN_HI  = ST_LEN_HI,
      S_LEN_LO  = ST_LEN_LO,
      S_DATA_HI = ST_DATA_HI,
      S_DATA_LO = ST_DATA_LO,
      S_CHECK   = ST_CHECK
   } ldr_state_t;

endpackage

// File: rtl/ram_loader_timer.sv
// Mid-frame idle watchdog: reloads on every byte, counts down while a frame is open,
// and flags expiry once TIMEOUT_CYCLES clocks have passed with no byte.
module loader_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset_,
   input  logic load,
   input  logic run,
   output logic expire
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= CW'(TIMEOUT_CYCLES);
      end else if (run && (cnt != '0)) begin
         cnt <= cnt - CW'(1);
      end
   end

   // A byte arriving in the expiry cycle wins: the reload suppresses the abort.
   assign expire = run && !load && (cnt == '0);

endmodule

// File: rtl/ram_loader.sv
// Framed byte-stream program loader: parses A5/addr/len/data/csum frames, writes 16-bit
// words into the RAM, and owns the RAM bus while a frame is open.
module ram_loader
   import ram_loader_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic                  clk,
   input  logic                  reset_,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [15:0]           cpu_din,
   input  logic                  cpu_we_,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [15:0]           ram_din,
   output logic                  ram_we_,
   output logic                  cpu_hold,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [3:0]            dbg_state
);

   // rx_valid is a one-cycle strobe with no backpressure: every cycle it is high
   // carries exactly one byte that is consumed in that cycle, whatever the state.

   ldr_state_t            state, state_nxt;
   logic [15:0]           addr_q;
   logic [15:0]           len_q;
   logic [7:0]            hi_q;
   logic [7:0]            csum;
   logic [ADDR_WIDTH-1:0] ld_addr;
   logic [15:0]           ld_din;
   logic                  ld_we_;
   logic                  done_q;
   logic                  error_q;
   logic                  tmr_expire;

   loader_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (clk),
      .reset_ (reset_),
      .load   (rx_valid),
      .run    (busy),
      .expire (tmr_expire)
   );

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (rx_valid) begin
         case (state)
            S_IDLE:    if (rx_data == LDR_HEADER) state_nxt = S_ADDR_HI;
            S_ADDR_HI: state_nxt = S_ADDR_LO;
            S_ADDR_LO: state_nxt = S_LEN_HI;
            S_LEN_HI:  state_nxt = S_LEN_LO;
            S_LEN_LO:  state_nxt = ({len_q[15:8], rx_data} == 16'd0) ? S_CHECK : S_DATA_HI;
            S_DATA_HI: state_nxt = S_DATA_LO;
            S_DATA_LO: state_nxt = (len_q == 16'd1) ? S_CHECK : S_DATA_HI;
            S_CHECK:   state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
         endcase
      end else if (tmr_expire) begin
         state_nxt = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         addr_q  <= '0;
         len_q   <= '0;
         hi_q    <= '0;
         csum    <= '0;
         ld_addr <= '0;
         ld_din  <= '0;
         ld_we_  <= 1'b1;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         ld_we_ <= 1'b1;
         done_q <= 1'b0;
         if (rx_valid) begin
            case (state)
               S_IDLE: begin
                  if (rx_data == LDR_HEADER) begin
                     error_q <= 1'b0;
                     csum    <= '0;
                  end
               end
               S_ADDR_HI: addr_q[15:8] <= rx_data;
               S_ADDR_LO: addr_q[7:0]  <= rx_data;
               S_LEN_HI:  len_q[15:8]  <= rx_data;
               S_LEN_LO:  len_q[7:0]   <= rx_data;
               S_DATA_HI: begin
                  hi_q <= rx_data;
                  csum <= csum + rx_data;
               end
               // Word is staged here and strobed next cycle; the 16-bit address
               // counter wraps naturally, and its low bits wrap mod 2^ADDR_WIDTH.
               S_DATA_LO: begin
                  ld_we_  <= 1'b0;
                  ld_addr <= addr_q[ADDR_WIDTH-1:0];
                  ld_din  <= {hi_q, rx_data};
                  addr_q  <= addr_q + 16'd1;
                  len_q   <= len_q - 16'd1;
                  csum    <= csum + rx_data;
               end
               S_CHECK: begin
                  if (rx_data == csum) done_q  <= 1'b1;
                  else                 error_q <= 1'b1;
               end
               default: ;
            endcase
         end else if (tmr_expire) begin
            error_q <= 1'b1;
         end
      end
   end

   assign busy      = (state != S_IDLE);
   assign cpu_hold  = busy | ~ld_we_;
   assign done      = done_q;
   assign error     = error_q;
   assign dbg_state = state;

   assign ram_addr = busy ? ld_addr : cpu_addr;
   assign ram_din  = busy ? ld_din  : cpu_din;
   assign ram_we_  = busy ? ld_we_  : cpu_we_;

endmodule
